// File: rtl/ec_pkg.sv
// rtl/ec_pkg.sv - shared types and constants for the error-check sequencer
package ec_pkg;

    localparam int EC_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EVAL,
        ST_HOLD
    } ec_state_t;

    localparam logic [1:0] EC_RES_CLEAN = 2'b00;
    localparam logic [1:0] EC_RES_CORR  = 2'b01;
    localparam logic [1:0] EC_RES_FAIL  = 2'b10;

endpackage

// File: rtl/ec_sat_cnt16.sv
// rtl/ec_sat_cnt16.sv - event counter that sticks at all-ones instead of wrapping
module ec_sat_cnt16
    import ec_pkg::*;
#(
    parameter logic [EC_CNT_W-1:0] INIT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [EC_CNT_W-1:0] count
);

    localparam logic [EC_CNT_W-1:0] ONE = {{(EC_CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= INIT;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/ec_err_seq_5l.sv
// rtl/ec_err_seq_5l.sv - sequences one detector pass per check request, retries
// malfunctions and holds a verdict until the consumer takes it
module ec_err_seq_5l
    import ec_pkg::*;
#(
    parameter int                  DET_LAT   = 6,
    parameter int                  MAX_RETRY = 3,
    parameter logic [EC_CNT_W-1:0] NORM_INIT = '0,
    parameter logic [EC_CNT_W-1:0] FAIL_INIT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chk_req,
    output logic                chk_rdy,
    output logic                det_go,
    input  logic                dig_norm_err,
    input  logic                dig_malf_err,
    input  logic                dig_uncor_err,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [1:0]          res_code,
    output logic [2:0]          retry_cnt,
    output logic [EC_CNT_W-1:0] norm_cnt,
    output logic [EC_CNT_W-1:0] fail_cnt,
    output logic                busy
);

    ec_state_t  state;
    logic [3:0] lat_cnt;
    logic       retry_ok;
    logic       norm_inc;
    logic       fail_inc;

    assign retry_ok = retry_cnt < 3'(MAX_RETRY);
    assign norm_inc = (state == ST_EVAL) && !dig_uncor_err && !dig_malf_err && dig_norm_err;
    assign fail_inc = (state == ST_EVAL) && (dig_uncor_err || (dig_malf_err && !retry_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            chk_rdy   <= 1'b0;
            det_go    <= 1'b0;
            res_valid <= 1'b0;
            res_code  <= EC_RES_CLEAN;
            retry_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (chk_req && chk_rdy) begin
                        state     <= ST_ISSUE;
                        chk_rdy   <= 1'b0;
                        det_go    <= 1'b1;
                        busy      <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        chk_rdy <= 1'b1;
                    end
                end
                // lat_cnt holds the detector cycles still outstanding after this one
                ST_ISSUE: begin
                    det_go  <= 1'b0;
                    lat_cnt <= 4'(DET_LAT - 1);
                    state   <= (DET_LAT == 1) ? ST_EVAL : ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (dig_malf_err && !dig_uncor_err && retry_ok) begin
                        retry_cnt <= retry_cnt + 3'd1;
                        det_go    <= 1'b1;
                        state     <= ST_ISSUE;
                    end else begin
                        state     <= ST_HOLD;
                        res_valid <= 1'b1;
                        if (fail_inc) begin
                            res_code <= EC_RES_FAIL;
                        end else if (norm_inc) begin
                            res_code <= EC_RES_CORR;
                        end else begin
                            res_code <= EC_RES_CLEAN;
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        chk_rdy   <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ec_sat_cnt16 #(.INIT(NORM_INIT)) u_norm_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (norm_inc),
        .count (norm_cnt)
    );

    ec_sat_cnt16 #(.INIT(FAIL_INIT)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_inc),
        .count (fail_cnt)
    );

endmodule

// File: tb/tb_ec_err_seq_5l.sv
// tb/tb_ec_err_seq_5l.sv - self-checking bench for ec_err_seq_5l
module tb_ec_err_seq_5l;

    localparam int DET_LAT    = 6;
    localparam int MAX_RETRY  = 3;
    localparam int NORM2_INIT = 65534;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       chk_req   = 1'b0;
    logic       res_ready = 1'b1;
    logic [2:0] fl        = 3'b000;  // {uncor, malf, norm}

    logic        chk_rdy, det_go, res_valid, busy;
    logic [1:0]  res_code;
    logic [2:0]  retry_cnt;
    logic [15:0] norm_cnt, fail_cnt;

    logic        chk_rdy_b, det_go_b, res_valid_b, busy_b;
    logic [1:0]  res_code_b;
    logic [2:0]  retry_cnt_b;
    logic [15:0] norm_cnt_b, fail_cnt_b;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef enum {M_FREE, M_CHECK, M_HOLD} mode_t;
    mode_t      m_mode  = M_FREE;
    logic       m_rdy   = 1'b0;
    int         m_go    = 0;
    int         m_retry = 0;
    logic [1:0] m_code  = 2'b00;
    int         m_norm  = 0;
    int         m_fail  = 0;
    int         m_norm2 = NORM2_INIT;

    ec_err_seq_5l #(.DET_LAT(DET_LAT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .chk_req(chk_req), .chk_rdy(chk_rdy), .det_go(det_go),
        .dig_norm_err(fl[0]), .dig_malf_err(fl[1]), .dig_uncor_err(fl[2]),
        .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .retry_cnt(retry_cnt), .norm_cnt(norm_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );

    ec_err_seq_5l #(.DET_LAT(DET_LAT), .MAX_RETRY(MAX_RETRY), .NORM_INIT(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .chk_req(chk_req), .chk_rdy(chk_rdy_b), .det_go(det_go_b),
        .dig_norm_err(fl[0]), .dig_malf_err(fl[1]), .dig_uncor_err(fl[2]),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_code(res_code_b),
        .retry_cnt(retry_cnt_b), .norm_cnt(norm_cnt_b), .fail_cnt(fail_cnt_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a check is a series of detector passes spaced DET_LAT+1 apart,
    // judged at det_go + DET_LAT; cyc is the cycle that is ending at this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_FREE; m_rdy = 1'b0; m_retry = 0; m_code = 2'b00;
            m_norm = 0; m_fail = 0; m_norm2 = NORM2_INIT;
        end else begin
            case (m_mode)
                M_FREE: begin
                    if (m_rdy && chk_req) begin
                        m_mode = M_CHECK; m_go = cyc + 1; m_retry = 0; m_rdy = 1'b0;
                    end else begin
                        m_rdy = 1'b1;
                    end
                end
                M_CHECK: begin
                    if (cyc == m_go + DET_LAT) begin
                        if (fl[1] && !fl[2] && m_retry < MAX_RETRY) begin
                            m_retry++;
                            m_go = cyc + 1;
                        end else begin
                            m_mode = M_HOLD;
                            if (fl[2] || fl[1]) begin
                                m_code = 2'b10;
                                if (m_fail < 65535) m_fail++;
                            end else if (fl[0]) begin
                                m_code = 2'b01;
                                if (m_norm < 65535) m_norm++;
                                if (m_norm2 < 65535) m_norm2++;
                            end else begin
                                m_code = 2'b00;
                            end
                        end
                    end
                end
                default: begin
                    if (res_ready) begin
                        m_mode = M_FREE; m_rdy = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        logic [8:0] ec;
        ec = {m_rdy, (m_mode == M_CHECK) && (cyc == m_go), m_mode == M_HOLD, m_code,
              3'(m_retry), m_mode != M_FREE};
        check("cycle_a",
              64'({chk_rdy, det_go, res_valid, res_code, retry_cnt, busy, norm_cnt, fail_cnt}),
              64'({ec, 16'(m_norm), 16'(m_fail)}));
        check("cycle_b",
              64'({chk_rdy_b, det_go_b, res_valid_b, res_code_b, retry_cnt_b, busy_b, norm_cnt_b, fail_cnt_b}),
              64'({ec, 16'(m_norm2), 16'(m_fail)}));
    end

    task automatic run_one(input logic [2:0] f_first, input logic [2:0] f_later,
                           output int n_go, output int first_go, output int gap, output int t_valid);
        int t0, last_go, k;
        n_go = 0; first_go = -1; gap = -1; t_valid = -1; last_go = 0; k = 0;
        while (!chk_rdy && k < 50) begin
            tick();
            k++;
        end
        t0 = cyc;
        fl = 3'b000;
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (det_go) begin
                n_go++;
                if (n_go == 1) first_go = cyc - t0;
                else gap = cyc - last_go;
                last_go = cyc;
                fl = (n_go == 1) ? f_first : f_later;
            end
            if (res_valid) begin
                t_valid = cyc - t0;
                break;
            end
            tick();
        end
        fl = 3'b000;
    endtask

    initial begin
        int n_go, first_go, gap, t_valid;
        logic bad;

        repeat (3) tick();
        check("reset_state",
              64'({chk_rdy, det_go, res_valid, res_code, retry_cnt, busy, norm_cnt, fail_cnt}), 64'(0));
        rst_n = 1'b1;
        tick();
        check("rdy_after_release", 64'(chk_rdy), 64'(1));

        run_one(3'b000, 3'b000, n_go, first_go, gap, t_valid);
        check("clean_first_go", 64'(first_go), 64'(1));
        check("clean_valid_cycle", 64'(t_valid), 64'(8));
        check("clean_go_count", 64'(n_go), 64'(1));
        check("clean_code_cnts", 64'({res_code, retry_cnt, norm_cnt, fail_cnt}), 64'(0));
        tick();
        check("clean_rdy_back", 64'({res_valid, chk_rdy}), 64'(2'b01));

        run_one(3'b001, 3'b001, n_go, first_go, gap, t_valid);
        check("norm_code_retry", 64'({res_code, retry_cnt}), 64'({2'b01, 3'd0}));
        check("norm_cnt_1", 64'(norm_cnt), 64'(1));
        check("norm_sat_1st", 64'(norm_cnt_b), 64'(16'hFFFF));

        run_one(3'b010, 3'b000, n_go, first_go, gap, t_valid);
        check("malf_clean_gos", 64'(n_go), 64'(2));
        check("malf_clean_gap", 64'(gap), 64'(7));
        check("malf_clean_code", 64'({res_code, retry_cnt}), 64'({2'b00, 3'd1}));

        run_one(3'b010, 3'b010, n_go, first_go, gap, t_valid);
        check("exhaust_gos", 64'(n_go), 64'(4));
        check("exhaust_code", 64'({res_code, retry_cnt, fail_cnt}), 64'({2'b10, 3'd3, 16'd1}));

        run_one(3'b111, 3'b000, n_go, first_go, gap, t_valid);
        check("all_flags_gos", 64'(n_go), 64'(1));
        check("all_flags_code", 64'({res_code, retry_cnt, fail_cnt}), 64'({2'b10, 3'd0, 16'd2}));

        run_one(3'b001, 3'b001, n_go, first_go, gap, t_valid);
        check("norm_sat_2nd", 64'(norm_cnt_b), 64'(16'hFFFF));
        run_one(3'b001, 3'b001, n_go, first_go, gap, t_valid);
        check("norm_sat_3rd", 64'(norm_cnt_b), 64'(16'hFFFF));
        check("norm_cnt_3", 64'(norm_cnt), 64'(3));

        res_ready = 1'b0;
        run_one(3'b001, 3'b001, n_go, first_go, gap, t_valid);
        for (int i = 0; i < 5; i++) begin
            chk_req = 1'b1;
            tick();
            check("bp_hold", 64'({res_valid, res_code, det_go, chk_rdy}), 64'({1'b1, 2'b01, 1'b0, 1'b0}));
        end
        chk_req = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_release", 64'({res_valid, chk_rdy}), 64'(2'b01));

        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid",
              64'({chk_rdy, det_go, res_valid, busy, norm_cnt, fail_cnt, norm_cnt_b}),
              64'({4'b0000, 16'h0000, 16'h0000, 16'hFFFE}));
        bad = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid || det_go) bad = 1'b1;
        end
        check("rst_no_verdict", 64'(bad), 64'(0));
        check("rst_rdy", 64'(chk_rdy), 64'(1));

        for (int i = 0; i < 4000; i++) begin
            chk_req   = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            fl        = {$urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3};
            rst_n     = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
